// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature decoder slice: FSM states, direction
// encoding, default debounce length, counter width and the 2-bit {A,B} phase
// constants plus the forward-successor helper.
// Latency: n/a (package). Backpressure: n/a.
package quad_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    localparam logic DIR_FWD = 1'b1;
    localparam logic DIR_REV = 1'b0;

    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int CNT_W               = 8;

    // {A,B} quadrature phases
    localparam logic [1:0] QS_00 = 2'b00;
    localparam logic [1:0] QS_01 = 2'b01;
    localparam logic [1:0] QS_11 = 2'b11;
    localparam logic [1:0] QS_10 = 2'b10;

    // Forward order is 00 -> 01 -> 11 -> 10 -> 00.
    function automatic logic [1:0] fwd_next(input logic [1:0] s);
        case (s)
            QS_00:   return QS_01;
            QS_01:   return QS_11;
            QS_11:   return QS_10;
            default: return QS_00;
        endcase
    endfunction

endpackage

// File: rtl/quad_encoder_decoder_if.sv
// Signal bundle between an encoder front end and the quadrature decoder.
// Latency: n/a (wiring only). Backpressure: none, inputs are sampled every cycle.
// master drives the raw channels and controls; slave (the decoder) drives step/dir/err.
interface quad_encoder_decoder_if;
    logic enc_a;    // raw channel A, asynchronous to clk
    logic enc_b;    // raw channel B, asynchronous to clk
    logic en;       // step enable
    logic err_clr;  // clears sticky err
    logic step;     // one-cycle pulse per legal transition
    logic dir;      // 1 = forward, 0 = reverse
    logic err;      // sticky illegal-transition flag

    modport master (
        output enc_a, enc_b, en, err_clr,
        input  step, dir, err
    );

    modport slave (
        input  enc_a, enc_b, en, err_clr,
        output step, dir, err
    );
endinterface

// File: rtl/enc_debounce.sv
// One encoder channel: 2-flop synchronizer, debounce counter and filtered value.
// Latency: raw change stable from sample edge 1 -> filt updates at edge 2+DEBOUNCE_CYCLES.
// Backpressure: none; ports clk, rst (sync, active-low), raw in, filt/settled out.
module enc_debounce
    import quad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic filt,
    output logic settled
);

    // The edge that would bring the count to DEBOUNCE_CYCLES is the one that
    // commits the new value, so we compare against DEBOUNCE_CYCLES-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             filt_q, filt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       prime_q, prime_d;

    always_comb begin
        filt_d  = filt_q;
        cnt_d   = '0;
        prime_d = {prime_q[0], 1'b1};
        if (sync2_q != filt_q) begin
            if (cnt_q == CNT_LAST) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            filt_q  <= 1'b0;
            cnt_q   <= '0;
            prime_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
            prime_q <= prime_d;
        end
    end

    assign filt = filt_q;

    // Zero count alone is true straight out of reset, before the pin has even
    // reached sync2. prime_q holds settled off until the synchronizer carries a
    // real sample, so the decoder latches the pin's true level, not the reset 0.
    assign settled = prime_q[1] && (cnt_q == '0) && (sync2_q == filt_q);

endmodule

// File: rtl/quad_encoder_decoder.sv
// Quadrature decoder: debounced A/B channels feed an INIT/TRACK FSM emitting step/dir/err.
// Latency: raw edge sampled at edge 1 -> step high in the cycle after edge 3+DEBOUNCE_CYCLES.
// Backpressure: none; ports clk, rst (sync, active-low) and the slave side of quad_encoder_decoder_if.
module quad_encoder_decoder
    import quad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    quad_encoder_decoder_if.slave  bus
);

    logic       filt_a, filt_b;
    logic       settled_a, settled_b;
    logic [1:0] cur;

    state_t     state_q, state_d;
    logic [1:0] prev_q, prev_d;
    logic       step_q, step_d;
    logic       dir_q, dir_d;
    logic       err_q, err_d;

    enc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .clk     (clk),
        .rst     (rst),
        .raw     (bus.enc_a),
        .filt    (filt_a),
        .settled (settled_a)
    );

    enc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .clk     (clk),
        .rst     (rst),
        .raw     (bus.enc_b),
        .filt    (filt_b),
        .settled (settled_b)
    );

    assign cur = {filt_a, filt_b};

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        step_d  = 1'b0;
        dir_d   = dir_q;
        err_d   = err_q;

        // Clear first so a simultaneous illegal transition below wins.
        if (bus.err_clr) begin
            err_d = 1'b0;
        end

        case (state_q)
            ST_INIT: begin
                if (settled_a && settled_b) begin
                    prev_d  = cur;
                    state_d = ST_TRACK;
                end
            end
            ST_TRACK: begin
                prev_d = cur;
                if (cur == ~prev_q) begin
                    // Both phases moved at once: direction unknowable.
                    err_d = 1'b1;
                end else if (cur != prev_q) begin
                    dir_d  = (cur == fwd_next(prev_q)) ? DIR_FWD : DIR_REV;
                    // With very short debounce the two channels can commit on
                    // back-to-back edges; the second pulse is dropped so the
                    // counter enable never stays high for two cycles.
                    step_d = bus.en && !step_q;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_INIT;
            prev_q  <= QS_00;
            step_q  <= 1'b0;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            step_q  <= step_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
        end
    end

    assign bus.step = step_q;
    assign bus.dir  = dir_q;
    assign bus.err  = err_q;

endmodule

// File: tb/tb_quad_encoder_decoder.sv
// Directed bench for quad_encoder_decoder with DEBOUNCE_CYCLES=4.
// Latency: step expected in the cycle after the 7th edge following a raw change.
// Backpressure: n/a; inputs are driven 1 time unit after the rising edge.
module tb_quad_encoder_decoder;
    import quad_pkg::*;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;
    int   step_cnt;
    int   consec_cnt;
    logic last_step;
    int   base;

    quad_encoder_decoder_if bus ();

    quad_encoder_decoder #(.DEBOUNCE_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Step pulse bookkeeping, sampled mid-cycle.
    initial begin
        step_cnt   = 0;
        consec_cnt = 0;
        last_step  = 1'b0;
    end
    always @(negedge clk) begin
        if (bus.step === 1'b1) begin
            step_cnt = step_cnt + 1;
            if (last_step === 1'b1) consec_cnt = consec_cnt + 1;
        end
        last_step = bus.step;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Drive a new {A,B}, hold 10 cycles, check step is high only after edge 7.
    task automatic move(input logic a, input logic b, input logic exp_step, input string tag);
        bus.enc_a = a;
        bus.enc_b = b;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk(tag, 32'(bus.step), 32'((k == 7) && exp_step));
        end
    endtask

    initial begin
        n_chk       = 0;
        n_err       = 0;
        rst         = 1'b0;
        bus.enc_a   = 1'b1;
        bus.enc_b   = 1'b1;
        bus.en      = 1'b1;
        bus.err_clr = 1'b0;

        // Reset with both channels high: INIT must latch 11, not the reset zero.
        ticks(3);
        chk("rst_step", 32'(bus.step), 32'd0);
        chk("rst_dir", 32'(bus.dir), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_state", 32'(dut.state_q), 32'(ST_INIT));
        rst = 1'b1;
        ticks(12);
        chk("init11_state", 32'(dut.state_q), 32'(ST_TRACK));
        chk("init11_prev", 32'(dut.prev_q), 32'h3);
        chk("init11_err", 32'(bus.err), 32'd0);
        chk("init11_steps", 32'(step_cnt), 32'd0);

        // Restart from 00 for the forward sequence.
        rst       = 1'b0;
        bus.enc_a = 1'b0;
        bus.enc_b = 1'b0;
        ticks(2);
        rst = 1'b1;
        ticks(5);
        chk("init00_prev", 32'(dut.prev_q), 32'h0);
        base = step_cnt;
        move(1'b0, 1'b1, 1'b1, "fwd_01");
        move(1'b1, 1'b1, 1'b1, "fwd_11");
        move(1'b1, 1'b0, 1'b1, "fwd_10");
        move(1'b0, 1'b0, 1'b1, "fwd_00");
        chk("fwd_steps", 32'(step_cnt - base), 32'd4);
        chk("fwd_dir", 32'(bus.dir), 32'(DIR_FWD));

        // Reverse 00 -> 10 -> 11 -> 01.
        base = step_cnt;
        move(1'b1, 1'b0, 1'b1, "rev_10");
        move(1'b1, 1'b1, 1'b1, "rev_11");
        move(1'b0, 1'b1, 1'b1, "rev_01");
        chk("rev_steps", 32'(step_cnt - base), 32'd3);
        chk("rev_dir", 32'(bus.dir), 32'(DIR_REV));
        move(1'b0, 1'b0, 1'b1, "rev_00");

        // Three-cycle glitch on A is filtered out.
        base      = step_cnt;
        bus.enc_a = 1'b1;
        ticks(3);
        bus.enc_a = 1'b0;
        ticks(10);
        chk("glitch3_steps", 32'(step_cnt - base), 32'd0);
        chk("glitch3_filt", 32'(dut.u_deb_a.filt_q), 32'd0);

        // Four-cycle pulse on A gets through: 00 -> 10 (reverse), then back.
        base      = step_cnt;
        bus.enc_a = 1'b1;
        ticks(4);
        bus.enc_a = 1'b0;
        ticks(5);
        chk("pulse4_steps", 32'(step_cnt - base), 32'd1);
        chk("pulse4_dir", 32'(bus.dir), 32'(DIR_REV));
        ticks(10);
        chk("pulse4_back_steps", 32'(step_cnt - base), 32'd2);
        chk("pulse4_back_dir", 32'(bus.dir), 32'(DIR_FWD));

        // Illegal 00 -> 11: err, no step, dir untouched.
        move(1'b1, 1'b1, 1'b0, "ill_11");
        chk("ill_err", 32'(bus.err), 32'd1);
        chk("ill_dir", 32'(bus.dir), 32'(DIR_FWD));
        chk("ill_prev", 32'(dut.prev_q), 32'h3);

        // err_clr on the same edge as a second illegal jump: set wins.
        bus.enc_a = 1'b0;
        bus.enc_b = 1'b0;
        ticks(6);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        chk("clr_vs_set_err", 32'(bus.err), 32'd1);
        chk("clr_vs_set_prev", 32'(dut.prev_q), 32'h0);
        ticks(3);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        chk("clr_alone_err", 32'(bus.err), 32'd0);

        // Reverse step so dir is 0, then a forward step with en=0.
        move(1'b1, 1'b0, 1'b1, "pre_en_10");
        chk("pre_en_dir", 32'(bus.dir), 32'(DIR_REV));
        bus.en = 1'b0;
        move(1'b0, 1'b0, 1'b0, "en0_00");
        chk("en0_dir", 32'(bus.dir), 32'(DIR_FWD));
        chk("en0_prev", 32'(dut.prev_q), 32'h0);

        // Reset while B is mid-debounce with en=0.
        base      = step_cnt;
        bus.enc_b = 1'b1;
        ticks(4);
        rst = 1'b0;
        tick();
        chk("midrst_step", 32'(bus.step), 32'd0);
        chk("midrst_dir", 32'(bus.dir), 32'd0);
        chk("midrst_err", 32'(bus.err), 32'd0);
        chk("midrst_state", 32'(dut.state_q), 32'(ST_INIT));
        chk("midrst_filt_b", 32'(dut.u_deb_b.filt_q), 32'd0);
        chk("midrst_cnt_b", 32'(dut.u_deb_b.cnt_q), 32'd0);
        rst    = 1'b1;
        bus.en = 1'b1;
        ticks(12);
        chk("midrst_steps", 32'(step_cnt - base), 32'd0);
        chk("midrst_prev", 32'(dut.prev_q), 32'h1);
        chk("midrst_err2", 32'(bus.err), 32'd0);

        chk("no_consec_step", 32'(consec_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/quad_encoder_decoder.md
QUAD_ENCODER_DECODER -- requirements
Module: quad_encoder_decoder

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, range 1..255: consecutive stable synchronized samples required before a channel's filtered value updates.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-004 SHALL have port enc_a  input  1  raw encoder channel A, asynchronous to clk.
REQ-005 SHALL have port enc_b  input  1  raw encoder channel B, asynchronous to clk.
REQ-006 SHALL have port en  input  1  step enable; 0 suppresses step, filtering and tracking continue.
REQ-007 SHALL have port err_clr  input  1  clears sticky err.
REQ-008 SHALL have port step  output  1  one-cycle pulse per legal quadrature transition; drives the position counter's count enable.
REQ-009 SHALL have port dir  output  1  direction of last legal transition; 1 = forward, 0 = reverse.
REQ-010 SHALL have port err  output  1  sticky illegal-transition flag.

Function
REQ-011 Each channel SHALL pass through a 2-flop synchronizer (sync1, sync2) before any other logic.
REQ-012 Per channel: debounce counter increments on each edge where sync2 != filtered value; resets to 0 on any edge where sync2 == filtered value.
REQ-013 When the counter reaches DEBOUNCE_CYCLES, the filtered value SHALL take sync2 on that edge and the counter SHALL return to 0.
REQ-014 Latency: raw change sampled at edge 1 and held stable -> filtered update at edge 2+DEBOUNCE_CYCLES -> step high for the cycle after edge 3+DEBOUNCE_CYCLES.
REQ-015 Pulses shorter than DEBOUNCE_CYCLES synchronized samples SHALL produce no filtered change.
REQ-016 State machine SHALL have states INIT and TRACK; reset enters INIT.
REQ-017 INIT: on the first edge where both channels have a zero debounce count, SHALL latch filtered {A,B} as previous state, no step, no err, then go to TRACK.
REQ-018 TRACK: forward sequence {A,B} 00->01->11->10->00 SHALL pulse step (when en=1) and set dir=1.
REQ-019 TRACK: reverse sequence 00->10->11->01->00 SHALL pulse step (when en=1) and set dir=0.
REQ-020 TRACK: both filtered bits changing on the same edge SHALL set err=1, produce no step, leave dir unchanged, and adopt the new value as previous state.
REQ-021 No filtered change SHALL produce step=0.
REQ-022 When en=0, the previous state and dir SHALL still update; step SHALL stay 0; err detection SHALL remain active.
REQ-023 err_clr=1 SHALL clear err on the next edge.
REQ-024 An illegal transition coinciding with err_clr SHALL leave err=1 (set wins).
REQ-025 step SHALL never be high on two consecutive cycles.

Reset
REQ-026 rst=0 at an edge SHALL clear sync flops, filtered values, debounce counters, previous state, step, dir and err to 0, and enter INIT.
REQ-027 Reset asserted mid-debounce or mid-pulse SHALL discard the pending update; step SHALL be 0 in the cycle after the reset edge.

Structure
REQ-028 Package quad_pkg SHALL hold: INIT/TRACK state encoding, DIR_FWD=1/DIR_REV=0, default DEBOUNCE_CYCLES, and the 2-bit quadrature state constants.
REQ-029 Sub-module enc_debounce (synchronizer + debounce counter + filtered value, parameter DEBOUNCE_CYCLES) SHALL be instantiated once per channel.
REQ-030 Debounce counter width SHALL be 8 bits.

Verification (DEBOUNCE_CYCLES=4)
REQ-031 Reset, hold A=1,B=1 -> INIT latches 11, no step, err=0.
REQ-032 Drive 00->01->11->10->00, each held 10 cycles -> 4 step pulses, dir=1, each 7 edges after the raw change.
REQ-033 Reverse sequence 00->10->11->01 -> 3 steps, dir=0.
REQ-034 A glitch high for 3 cycles -> no step, filtered A unchanged; glitch held 4+ cycles -> 1 step.
REQ-035 Jump 00->11 in one cycle -> err=1, no step; assert err_clr together with a second illegal jump -> err stays 1; err_clr alone -> err=0.
REQ-036 en=0 during a forward transition, then rst=0 mid-debounce -> no step, all outputs 0, state INIT.
